cgra_issue_ctrl: RTL and testbench

Instruction issue sequencer for one CGRA vector PE. Fetches 32-bit RISC-V-style instructions from a synchronous-read instruction memory and presents each one, registered, to the PE's instruction decoder. Uses the decoder's classification outputs to advance the PC, resolve `beq`, latch the vector length written by `vsetivli`, and stall on vector instructions. While a vector instruction runs, it drives one element beat per accepted cycle to the vector datapath.

---
 rtl/cgra_issue_ctrl_pkg.sv | 24 ++
 rtl/cgra_issue_ctrl_if.sv | 44 ++++
 rtl/cgra_issue_ctrl_vec_beat_counter.sv | 34 +++
 rtl/cgra_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_cgra_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_issue_ctrl_pkg.sv
// Shared types and constants for the CGRA issue sequencer.
//   issue_state_t        - sequencer FSM encoding
//   PC_STEP              - byte increment for a sequential instruction
//   DEF_DWIDTH_*         - shared datapath widths (instruction, vector length
//                          / element index, scalar data)
package cgra_issue_pkg;

  localparam int DEF_PC_W         = 12;
  localparam int DEF_DWIDTH_INST  = 32;
  localparam int DEF_DWIDTH_RFADD = 12;
  localparam int DEF_DWIDTH_INT   = 32;

  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DECODE = 3'd3,
    ST_VEXEC  = 3'd4,
    ST_DONE   = 3'd5
  } issue_state_t;

endpackage

// File: rtl/cgra_issue_ctrl_if.sv
// Issue-sequencer side bus: instruction memory, decoder classification,
// scalar RF read data and vector element beats.
//   master : the sequencer (drives imem request, instruction, beats)
//   slave  : the environment (memory, decoder, RF, vector datapath)
interface cgra_issue_ctrl_if
  import cgra_issue_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int dwidth_inst  = DEF_DWIDTH_INST,
  parameter int dwidth_RFadd = DEF_DWIDTH_RFADD,
  parameter int dwidth_int   = DEF_DWIDTH_INT
);
  logic                    imem_rd_en;
  logic [PC_W-3:0]         imem_addr;
  logic [dwidth_inst-1:0]  imem_rdata;
  logic [dwidth_inst-1:0]  instr_o;
  logic                    instr_valid;
  logic                    dec_is_not_vect;
  logic                    dec_is_beq;
  logic                    dec_wen_ITR;
  logic [dwidth_RFadd-1:0] dec_ITR;
  logic [11:0]             dec_branch_immediate;
  logic [dwidth_int-1:0]   rs1_data;
  logic [dwidth_int-1:0]   rs2_data;
  logic                    vec_active;
  logic                    vec_ready;
  logic [dwidth_RFadd-1:0] vec_elem_idx;
  logic                    vec_last;

  modport master (
    output imem_rd_en, imem_addr, instr_o, instr_valid,
           vec_active, vec_elem_idx, vec_last,
    input  imem_rdata, dec_is_not_vect, dec_is_beq, dec_wen_ITR, dec_ITR,
           dec_branch_immediate, rs1_data, rs2_data, vec_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, instr_o, instr_valid,
           vec_active, vec_elem_idx, vec_last,
    output imem_rdata, dec_is_not_vect, dec_is_beq, dec_wen_ITR, dec_ITR,
           dec_branch_immediate, rs1_data, rs2_data, vec_ready
  );

endinterface

// File: rtl/cgra_issue_ctrl_vec_beat_counter.sv
// Element index counter for one vector instruction.
//   load   : restart at element 0
//   vl     : vector length (element count)
//   ready  : beat accepted this cycle (already qualified by the caller)
//   idx    : current element index
//   last   : idx is the final element
//   finish : final element accepted this cycle
module vec_beat_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] vl,
  input  logic         ready,
  output logic [W-1:0] idx,
  output logic         last,
  output logic         finish
);

  assign last   = (idx == (vl - W'(1)));
  assign finish = ready & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (load || finish) begin
      idx <= '0;
    end else if (ready) begin
      idx <= idx + W'(1);
    end
  end

endmodule

// File: rtl/cgra_issue_ctrl.sv
// Instruction issue sequencer for one CGRA vector PE.
// Fetches from a synchronous-read imem, registers the instruction for the
// decoder, advances the PC (sequential or taken beq), latches the vector
// length from vsetivli and stalls while a vector instruction emits beats.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   start, start_pc   - launch pulse (IDLE only) and byte start PC
//   prog_end          - byte PC at which the program ends
//   busy, done        - not-IDLE flag, one-cycle end-of-program pulse
//   bus (master)      - imem, decoder, RF data and vector beat signals
// Optional (macro ISSUE_PERF_CNT_EN):
//   perf_busy_cycles  - saturating count of busy cycles
//   perf_stall_cycles - saturating count of VEXEC cycles with vec_ready low
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start
// ST_FETCH  | end-of-program check, imem read strobe
// ST_LOAD   | capture imem read data into instr_q
// ST_DECODE | decoder outputs valid; update pc / vl_q
// ST_VEXEC  | emitting vector element beats
// ST_DONE   | one-cycle done pulse
module cgra_issue_ctrl
  import cgra_issue_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int dwidth_inst  = DEF_DWIDTH_INST,
  parameter int dwidth_RFadd = DEF_DWIDTH_RFADD,
  parameter int dwidth_int   = DEF_DWIDTH_INT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  input  logic [PC_W-1:0]      prog_end,
  output logic                 busy,
  output logic                 done,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0]          perf_busy_cycles,
  output logic [31:0]          perf_stall_cycles,
`endif
  cgra_issue_ctrl_if.master    bus
);

  issue_state_t            state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [dwidth_RFadd-1:0] vl_q, vl_d;
  logic [dwidth_inst-1:0]  instr_q, instr_d;
  logic                    start_acc;

  logic                    beat_load, beat_ready, beat_last, beat_finish;
  logic [dwidth_RFadd-1:0] beat_idx;

  logic [dwidth_int-1:0]   rs1_val, rs2_val;
  logic                    pc_at_end;
  // {sext(imm), 1'b0} built wide enough for any PC_W, then truncated
  logic [PC_W+12:0]        br_off_full;
  logic [PC_W-1:0]         br_off;

  assign rs1_val     = bus.rs1_data;
  assign rs2_val     = bus.rs2_data;
  assign pc_at_end   = (pc_q >= prog_end);
  assign br_off_full = {{PC_W{bus.dec_branch_immediate[11]}}, bus.dec_branch_immediate, 1'b0};
  assign br_off      = br_off_full[PC_W-1:0];
  assign beat_ready  = bus.vec_ready && (state_q == ST_VEXEC);

  vec_beat_counter #(.W(dwidth_RFadd)) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (beat_load),
    .vl     (vl_q),
    .ready  (beat_ready),
    .idx    (beat_idx),
    .last   (beat_last),
    .finish (beat_finish)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      vl_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vl_q    <= vl_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    vl_d      = vl_q;
    instr_d   = instr_q;
    beat_load = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d      = start_pc;
          start_acc = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = pc_at_end ? ST_DONE : ST_LOAD;
      ST_LOAD: begin
        instr_d = bus.imem_rdata;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (bus.dec_wen_ITR) vl_d = bus.dec_ITR;
        if (bus.dec_is_beq && (rs1_val == rs2_val)) pc_d = pc_q + br_off;
        else                                        pc_d = pc_q + PC_W'(PC_STEP);
        // vl_q here is the value before any vsetivli in this same instruction
        if (!bus.dec_is_not_vect && (vl_q != '0)) begin
          beat_load = 1'b1;
          state_d   = ST_VEXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_VEXEC: if (beat_finish) state_d = ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign bus.imem_rd_en   = (state_q == ST_FETCH) && !pc_at_end;
  assign bus.imem_addr    = pc_q[PC_W-1:2];
  assign bus.instr_o      = instr_q;
  assign bus.instr_valid  = (state_q == ST_DECODE) || (state_q == ST_VEXEC);
  assign bus.vec_active   = (state_q == ST_VEXEC);
  assign bus.vec_elem_idx = beat_idx;
  assign bus.vec_last     = (state_q == ST_VEXEC) && beat_last;

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (start_acc) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state_q == ST_VEXEC) && !bus.vec_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cgra_issue_ctrl.sv
// Directed testbench for cgra_issue_ctrl: small imem model, stub decoder,
// per-scenario tasks with hand-computed expectations.
module tb_cgra_issue_ctrl;

  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] ADDI  = 32'h00108093;
  localparam logic [31:0] VSET4 = 32'hC1027057;
  localparam logic [31:0] VSET0 = 32'hC1007057;
  localparam logic [31:0] VMACC = 32'hB620A057;
  localparam logic [31:0] BEQ   = 32'hFE208CE3; // beq x1,x2,-8

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] start_pc;
  logic [11:0] prog_end;
  logic        busy;
  logic        done;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];

  cgra_issue_ctrl_if bus ();

  cgra_issue_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .start_pc          (start_pc),
    .prog_end          (prog_end),
    .busy              (busy),
    .done              (done),
`ifdef ISSUE_PERF_CNT_EN
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .bus               (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  // stub decoder: OP-V funct3=111 is vsetivli (not vector), other OP-V is vector
  always_comb begin
    bus.dec_is_not_vect      = !((bus.instr_o[6:0] == 7'h57) && (bus.instr_o[14:12] != 3'b111));
    bus.dec_is_beq           = (bus.instr_o[6:0] == 7'h63) && (bus.instr_o[14:12] == 3'b000);
    bus.dec_wen_ITR          = (bus.instr_o[6:0] == 7'h57) && (bus.instr_o[14:12] == 3'b111);
    bus.dec_ITR              = {7'd0, bus.instr_o[19:15]};
    bus.dec_branch_immediate = {bus.instr_o[31], bus.instr_o[7], bus.instr_o[30:25], bus.instr_o[11:8]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, n);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if ({busy, done, bus.imem_rd_en, bus.instr_valid, bus.vec_active, bus.vec_last} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 000000",
        {busy, done, bus.imem_rd_en, bus.instr_valid, bus.vec_active, bus.vec_last}); end
    checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0h required 0", bus.imem_addr); end
    checks++; if (bus.instr_o !== 32'd0) begin errors++; $display("FAIL reset_instr: got %0h required 0", bus.instr_o); end
    checks++; if (bus.vec_elem_idx !== 12'd0) begin errors++; $display("FAIL reset_idx: got %0h required 0", bus.vec_elem_idx); end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_scalar();
    mem[0] = LUI; mem[1] = ADDI;
    start_pc = 12'h000; prog_end = 12'h008;
    pulse_start(); // cycle 1
    checks++; if ({busy, bus.imem_rd_en} !== 2'b11) begin errors++; $display("FAIL scalar_c1_fetch: got %b required 11", {busy, bus.imem_rd_en}); end
    checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL scalar_c1_addr: got %0h required 0", bus.imem_addr); end
    step(); // 2
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL scalar_c2_valid: got %b required 0", bus.instr_valid); end
    step(); // 3
    checks++; if ({bus.instr_valid, bus.instr_o} !== {1'b1, LUI}) begin errors++; $display("FAIL scalar_c3_decode: got %b/%h required 1/%h", bus.instr_valid, bus.instr_o, LUI); end
    step(); // 4
    checks++; if (bus.imem_addr !== 10'd1) begin errors++; $display("FAIL scalar_c4_addr: got %0h required 1", bus.imem_addr); end
    start_pc = 12'h100;
    pulse_start(); // 5, start must be ignored
    step(); // 6
    checks++; if ({bus.instr_valid, bus.instr_o} !== {1'b1, ADDI}) begin errors++; $display("FAIL scalar_c6_decode: got %b/%h required 1/%h", bus.instr_valid, bus.instr_o, ADDI); end
    step(); // 7
    checks++; if ({bus.imem_rd_en, done, bus.imem_addr} !== {2'b00, 10'd2}) begin errors++; $display("FAIL scalar_c7_end: got rd=%b done=%b addr=%0h required 0/0/2", bus.imem_rd_en, done, bus.imem_addr); end
    step(); // 8
    checks++; if ({done, busy} !== 2'b11) begin errors++; $display("FAIL scalar_c8_done: got %b required 11", {done, busy}); end
    step(); // 9
    checks++; if ({done, busy, bus.imem_addr} !== {2'b00, 10'd2}) begin errors++; $display("FAIL scalar_c9_idle: got done=%b busy=%b addr=%0h required 0/0/2", done, busy, bus.imem_addr); end
  endtask

  task automatic test_vector();
    mem[4] = VSET4; mem[5] = VMACC;
    start_pc = 12'h010; prog_end = 12'h018;
    bus.vec_ready = 1'b1;
    pulse_start(); // 1
    step(); step(); step(); // 4
    checks++; if ({bus.imem_rd_en, bus.vec_active, bus.imem_addr} !== {2'b10, 10'd5}) begin errors++; $display("FAIL vec_after_vset: got rd=%b act=%b addr=%0h required 1/0/5", bus.imem_rd_en, bus.vec_active, bus.imem_addr); end
    step(); step(); // 6
    checks++; if ({bus.vec_active, bus.instr_o} !== {1'b0, VMACC}) begin errors++; $display("FAIL vec_decode: got %b/%h required 0/%h", bus.vec_active, bus.instr_o, VMACC); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.vec_active, bus.instr_valid, bus.vec_elem_idx, bus.vec_last, bus.instr_o} !==
          {1'b1, 1'b1, 12'(i), (i == 3), VMACC}) begin
        errors++; $display("FAIL vec_beat%0d: got act=%b idx=%0d last=%b instr=%h required 1/%0d/%0b/%h",
          i, bus.vec_active, bus.vec_elem_idx, bus.vec_last, bus.instr_o, i, (i == 3), VMACC);
      end
    end
    step(); // 11
    checks++; if ({bus.vec_active, bus.imem_rd_en, busy} !== 3'b001) begin errors++; $display("FAIL vec_post_fetch: got %b required 001", {bus.vec_active, bus.imem_rd_en, busy}); end
    step(); // 12
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL vec_done: got %b required 1", done); end
    step();
  endtask

  task automatic test_backpressure();
    logic [5:0]  rdy = 6'b111001;  // bit i = ready in VEXEC cycle i
    logic [11:0] exp_idx [6] = '{12'd0, 12'd1, 12'd1, 12'd1, 12'd2, 12'd3};
    start_pc = 12'h010; prog_end = 12'h018;
    bus.vec_ready = 1'b1;
    pulse_start();
    step(); step(); step(); step(); step(); // 6
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({bus.vec_active, bus.vec_elem_idx, bus.vec_last} !== {1'b1, exp_idx[i], (i == 5)}) begin
        errors++; $display("FAIL bp_cycle%0d: got act=%b idx=%0d last=%b required 1/%0d/%0b",
          i, bus.vec_active, bus.vec_elem_idx, bus.vec_last, exp_idx[i], (i == 5));
      end
      bus.vec_ready = rdy[i];
    end
    bus.vec_ready = 1'b1;
    step(); // 13
    checks++; if (bus.vec_active !== 1'b0) begin errors++; $display("FAIL bp_end_active: got %b required 0", bus.vec_active); end
    step(); // 14
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b required 1", done); end
    step(); // 15
`ifdef ISSUE_PERF_CNT_EN
    checks++; if (perf_stall_cycles !== 32'd2) begin errors++; $display("FAIL bp_perf_stall: got %0d required 2", perf_stall_cycles); end
    checks++; if (perf_busy_cycles !== 32'd14) begin errors++; $display("FAIL bp_perf_busy: got %0d required 14", perf_busy_cycles); end
`endif
  endtask

  task automatic test_branch();
    mem[0] = LUI; mem[1] = ADDI; mem[2] = BEQ; mem[3] = ADDI;
    start_pc = 12'h008; prog_end = 12'h010;
    bus.rs1_data = 32'd5; bus.rs2_data = 32'd5;
    pulse_start(); // 1
    checks++; if (bus.imem_addr !== 10'd2) begin errors++; $display("FAIL br_start_addr: got %0h required 2", bus.imem_addr); end
    step(); step(); // 3
    checks++; if (bus.instr_o !== BEQ) begin errors++; $display("FAIL br_decode: got %h required %h", bus.instr_o, BEQ); end
    step(); // 4
    checks++; if ({bus.imem_rd_en, bus.imem_addr} !== {1'b1, 10'd0}) begin errors++; $display("FAIL br_taken_addr: got rd=%b addr=%0h required 1/0", bus.imem_rd_en, bus.imem_addr); end
    bus.rs2_data = 32'd6;
    for (int i = 0; i < 8; i++) step(); // 12
    checks++; if (bus.instr_o !== BEQ) begin errors++; $display("FAIL br_second_decode: got %h required %h", bus.instr_o, BEQ); end
    step(); // 13
    checks++; if ({bus.imem_rd_en, bus.imem_addr} !== {1'b1, 10'd3}) begin errors++; $display("FAIL br_not_taken_addr: got rd=%b addr=%0h required 1/3", bus.imem_rd_en, bus.imem_addr); end
    wait_done(10);
  endtask

  task automatic test_zero_len();
    mem[16] = VSET0; mem[17] = VMACC; mem[18] = ADDI;
    start_pc = 12'h040; prog_end = 12'h04C;
    pulse_start();
    for (int i = 0; i < 5; i++) step(); // 6
    checks++; if ({bus.instr_valid, bus.instr_o} !== {1'b1, VMACC}) begin errors++; $display("FAIL zl_decode: got %b/%h required 1/%h", bus.instr_valid, bus.instr_o, VMACC); end
    step(); // 7
    checks++; if ({bus.vec_active, bus.imem_rd_en, bus.imem_addr} !== {2'b01, 10'd18}) begin errors++; $display("FAIL zl_fetch: got act=%b rd=%b addr=%0d required 0/1/18", bus.vec_active, bus.imem_rd_en, bus.imem_addr); end
    wait_done(10);
  endtask

  task automatic test_reset_mid_run();
    start_pc = 12'h010; prog_end = 12'h018;
    bus.vec_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) step(); // 9, beat 2
    checks++; if ({bus.vec_active, bus.vec_elem_idx} !== {1'b1, 12'd2}) begin errors++; $display("FAIL rst_pre_beat: got act=%b idx=%0d required 1/2", bus.vec_active, bus.vec_elem_idx); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, bus.imem_rd_en, bus.instr_valid, bus.vec_active, bus.vec_last} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b required 000000",
        {busy, done, bus.imem_rd_en, bus.instr_valid, bus.vec_active, bus.vec_last}); end
    checks++; if ({bus.imem_addr, bus.instr_o, bus.vec_elem_idx} !== 54'd0) begin
      errors++; $display("FAIL rst_mid_values: got addr=%0h instr=%h idx=%0h required 0", bus.imem_addr, bus.instr_o, bus.vec_elem_idx); end
    #2 rst_n = 1'b1;
    step();
    start_pc = 12'h014; prog_end = 12'h018;
    pulse_start(); // 1
    checks++; if ({busy, bus.imem_rd_en, bus.imem_addr} !== {2'b11, 10'd5}) begin errors++; $display("FAIL rst_restart_fetch: got busy=%b rd=%b addr=%0h required 1/1/5", busy, bus.imem_rd_en, bus.imem_addr); end
    step(); step(); // 3
    checks++; if (bus.instr_o !== VMACC) begin errors++; $display("FAIL rst_restart_decode: got %h required %h", bus.instr_o, VMACC); end
    step(); // 4, vl_q cleared by reset so no beats
    checks++; if (bus.vec_active !== 1'b0) begin errors++; $display("FAIL rst_vl_cleared: got act=%b required 0", bus.vec_active); end
    wait_done(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = ADDI;
    rst_n = 1'b0; start = 1'b0; start_pc = '0; prog_end = '0;
    bus.vec_ready = 1'b0; bus.rs1_data = '0; bus.rs2_data = '0;
    test_reset();
    test_scalar();
    test_vector();
    test_backpressure();
    test_branch();
    test_zero_len();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
